// File: rtl/vdc_pkg.sv
// Shared types and register indices for the VDC CPU-access sequencer.
// Imported by vdc_cpuop_ctrl.
package vdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FILL,
        COPY_RD,
        COPY_WR
    } cpuop_t;

    localparam logic [5:0] R_UAH = 6'd18;
    localparam logic [5:0] R_UAL = 6'd19;
    localparam logic [5:0] R_WC  = 6'd30;
    localparam logic [5:0] R_DA  = 6'd31;
    localparam logic [5:0] R_BAH = 6'd32;
    localparam logic [5:0] R_BAL = 6'd33;

endpackage

// File: rtl/vdc_cpuop_ctrl.sv
// CPU-initiated VDC RAM sequencer: DA read-ahead/write, block fill and copy.
// Requests column slots from the scheduler via req/grant/done.
module vdc_cpuop_ctrl
    import vdc_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int WC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enableBus,
    input  logic              cs,
    input  logic              rs,
    input  logic              we,
    input  logic [5:0]        regA,
    input  logic [7:0]        db_in,
    input  logic              reg_copy,
    output logic              slot_req,
    input  logic              slot_grant,
    input  logic              slot_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] reg_ua,
    output logic [ADDR_W-1:0] reg_ba,
    output logic [WC_W-1:0]   reg_wc,
    output logic [7:0]        reg_da,
    output logic              busy
);

    cpuop_t            state;
    cpuop_t            pend_cmd;
    logic              inflight;
    logic              pend_valid;
    logic              pend_ua;
    logic              pend_cnt;
    logic [WC_W-1:0]   cnt;
    logic [7:0]        wda;
    logic [7:0]        cda;

    logic              bus_acc;
    logic              cmd_valid;
    cpuop_t            cmd_st;
    logic              cmd_ua;
    logic              cmd_cnt;
    logic [ADDR_W-1:0] ua_cmd;
    logic              grant_acc;
    logic              done_acc;
    logic              cmd_hold;

    assign bus_acc   = enableBus & cs & rs;
    assign slot_req  = (state != IDLE) & ~inflight;
    assign busy      = (state != IDLE) | inflight | pend_valid;
    assign grant_acc = slot_grant & slot_req;
    assign done_acc  = slot_done & inflight;
    // A grant taken this cycle counts as in flight for a new command.
    assign cmd_hold  = (inflight | grant_acc) & ~done_acc;

    always_comb begin
        cmd_valid = 1'b0;
        cmd_st    = IDLE;
        cmd_ua    = 1'b0;
        cmd_cnt   = 1'b0;
        ua_cmd    = reg_ua;
        if (bus_acc) begin
            if (!we) begin
                if (regA == R_DA) begin
                    cmd_valid = 1'b1;
                    cmd_st    = READ;
                    cmd_ua    = 1'b1;
                    ua_cmd    = reg_ua + 1'b1;
                end
            end else begin
                case (regA)
                    R_UAH: begin
                        cmd_valid = 1'b1;
                        cmd_st    = READ;
                        cmd_ua    = 1'b1;
                        ua_cmd    = {db_in, reg_ua[7:0]};
                    end
                    R_UAL: begin
                        cmd_valid = 1'b1;
                        cmd_st    = READ;
                        cmd_ua    = 1'b1;
                        ua_cmd    = {reg_ua[15:8], db_in};
                    end
                    R_WC: begin
                        cmd_valid = 1'b1;
                        cmd_st    = reg_copy ? COPY_RD : FILL;
                        cmd_cnt   = 1'b1;
                    end
                    R_DA: begin
                        cmd_valid = 1'b1;
                        cmd_st    = WRITE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend_cmd   <= IDLE;
            inflight   <= 1'b0;
            pend_valid <= 1'b0;
            pend_ua    <= 1'b0;
            pend_cnt   <= 1'b0;
            cnt        <= '0;
            wda        <= '0;
            cda        <= '0;
            reg_ua     <= '0;
            reg_ba     <= '0;
            reg_wc     <= '0;
            reg_da     <= '0;
            mem_addr   <= '1;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            if (grant_acc) begin
                inflight <= 1'b1;
                case (state)
                    READ: begin
                        mem_addr <= reg_ua;
                        mem_we   <= 1'b0;
                    end
                    WRITE, FILL: begin
                        mem_addr  <= reg_ua;
                        mem_we    <= 1'b1;
                        mem_wdata <= wda;
                    end
                    COPY_RD: begin
                        mem_addr <= reg_ba;
                        mem_we   <= 1'b0;
                    end
                    COPY_WR: begin
                        mem_addr  <= reg_ua;
                        mem_we    <= 1'b1;
                        mem_wdata <= cda;
                    end
                    default: ;
                endcase
            end

            if (done_acc) begin
                inflight   <= 1'b0;
                mem_we     <= 1'b0;
                mem_addr   <= '1;
                pend_valid <= 1'b0;
                pend_ua    <= 1'b0;
                pend_cnt   <= 1'b0;
                // A pending UA/count load supersedes the increment.
                case (state)
                    READ: begin
                        reg_da <= mem_rdata;
                        state  <= IDLE;
                    end
                    WRITE: begin
                        if (!pend_ua) reg_ua <= reg_ua + 1'b1;
                        state <= READ;
                    end
                    FILL: begin
                        if (!pend_ua) reg_ua <= reg_ua + 1'b1;
                        if (!pend_cnt) cnt <= cnt - 1'b1;
                        state <= (cnt == 1) ? IDLE : FILL;
                    end
                    COPY_RD: begin
                        cda    <= mem_rdata;
                        reg_ba <= reg_ba + 1'b1;
                        state  <= COPY_WR;
                    end
                    COPY_WR: begin
                        if (!pend_ua) reg_ua <= reg_ua + 1'b1;
                        if (!pend_cnt) cnt <= cnt - 1'b1;
                        state <= (cnt == 1) ? IDLE : COPY_RD;
                    end
                    default: state <= IDLE;
                endcase
                if (pend_valid) state <= pend_cmd;
            end

            if (bus_acc && we && regA == R_BAH) reg_ba[15:8] <= db_in;
            if (bus_acc && we && regA == R_BAL) reg_ba[7:0]  <= db_in;

            if (cmd_valid) begin
                if (cmd_ua) reg_ua <= ua_cmd;
                if (cmd_cnt) begin
                    reg_wc <= db_in;
                    cnt    <= db_in;
                end
                if (we && regA == R_DA) wda <= db_in;
                if (cmd_hold) begin
                    pend_valid <= 1'b1;
                    pend_cmd   <= cmd_st;
                    pend_ua    <= pend_ua | cmd_ua;
                    pend_cnt   <= pend_cnt | cmd_cnt;
                end else begin
                    state <= cmd_st;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdc_cpuop_ctrl.sv
// Self-checking bench for vdc_cpuop_ctrl: vector table plus
// hand-written copy, 256-word fill, pending-command and reset sequences.
module tb_vdc_cpuop_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enableBus, cs, rs, we, reg_copy;
    logic [5:0]  regA;
    logic [7:0]  db_in;
    logic        slot_req, slot_grant, slot_done;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [15:0] reg_ua, reg_ba;
    logic [7:0]  reg_wc, reg_da;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vdc_cpuop_ctrl #(.ADDR_W(16), .WC_W(8)) dut (
        .clk(clk), .reset(reset), .enableBus(enableBus), .cs(cs),
        .rs(rs), .we(we), .regA(regA), .db_in(db_in),
        .reg_copy(reg_copy), .slot_req(slot_req),
        .slot_grant(slot_grant), .slot_done(slot_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .reg_ua(reg_ua), .reg_ba(reg_ba),
        .reg_wc(reg_wc), .reg_da(reg_da), .busy(busy)
    );

    typedef enum logic [2:0] {NOP, WR, RD, GNT, DN} op_t;

    typedef struct {
        op_t         op;
        logic [5:0]  ra;
        logic [7:0]  d;
        logic        req;
        logic [15:0] addr;
        logic        mwe;
        logic [7:0]  wd;
        logic [15:0] ua;
        logic [7:0]  da;
        logic [7:0]  wc;
        logic        bsy;
    } vec_t;

    vec_t vt[25];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input op_t op, input logic [5:0] ra,
                        input logic [7:0] d);
        enableBus  = (op == WR) || (op == RD);
        cs         = enableBus;
        rs         = enableBus;
        we         = (op == WR);
        regA       = ra;
        db_in      = d;
        slot_grant = (op == GNT);
        slot_done  = (op == DN);
        mem_rdata  = d;
        @(posedge clk);
        #1;
        enableBus  = 1'b0;
        cs         = 1'b0;
        rs         = 1'b0;
        we         = 1'b0;
        slot_grant = 1'b0;
        slot_done  = 1'b0;
    endtask

    task automatic do_slot(input string name, input logic [15:0] ea,
                           input logic ewe, input logic [7:0] ewd,
                           input logic [7:0] rdata);
        int w = 0;
        while (!slot_req && w < 20) begin
            step(NOP, 6'd0, 8'h00);
            w++;
        end
        if (!slot_req) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: slot_req never rose", name);
        end else begin
            step(GNT, 6'd0, 8'h00);
            check({name, " addr"}, mem_addr, ea);
            check({name, " we"}, mem_we, ewe);
            if (ewe) check({name, " wdata"}, mem_wdata, ewd);
            step(NOP, 6'd0, 8'h00);
            step(DN, 6'd0, rdata);
        end
    endtask

    function automatic vec_t mk(op_t op, logic [5:0] ra, logic [7:0] d,
                                logic req, logic [15:0] addr, logic mwe,
                                logic [7:0] wd, logic [15:0] ua,
                                logic [7:0] da, logic [7:0] wc,
                                logic bsy);
        vec_t v;
        v.op = op; v.ra = ra; v.d = d; v.req = req; v.addr = addr;
        v.mwe = mwe; v.wd = wd; v.ua = ua; v.da = da; v.wc = wc;
        v.bsy = bsy;
        return v;
    endfunction

    initial begin
        int n;
        logic [15:0] ea;

        vt[0]  = mk(NOP, 0,  8'h00, 0, 16'hFFFF, 0, 0, 16'h0000, 8'h00, 0, 0);
        vt[1]  = mk(WR, 18,  8'h12, 1, 16'hFFFF, 0, 0, 16'h1200, 8'h00, 0, 1);
        vt[2]  = mk(WR, 19,  8'h34, 1, 16'hFFFF, 0, 0, 16'h1234, 8'h00, 0, 1);
        vt[3]  = mk(GNT, 0,  8'h00, 0, 16'h1234, 0, 0, 16'h1234, 8'h00, 0, 1);
        vt[4]  = mk(NOP, 0,  8'h00, 0, 16'h1234, 0, 0, 16'h1234, 8'h00, 0, 1);
        vt[5]  = mk(DN,  0,  8'hAB, 0, 16'hFFFF, 0, 0, 16'h1234, 8'hAB, 0, 0);
        vt[6]  = mk(WR, 18,  8'h00, 1, 16'hFFFF, 0, 0, 16'h0034, 8'hAB, 0, 1);
        vt[7]  = mk(WR, 19,  8'hFF, 1, 16'hFFFF, 0, 0, 16'h00FF, 8'hAB, 0, 1);
        vt[8]  = mk(WR, 31,  8'h5A, 1, 16'hFFFF, 0, 0, 16'h00FF, 8'hAB, 0, 1);
        vt[9]  = mk(GNT, 0,  8'h00, 0, 16'h00FF, 1, 8'h5A, 16'h00FF, 8'hAB, 0, 1);
        vt[10] = mk(DN,  0,  8'h00, 1, 16'hFFFF, 0, 0, 16'h0100, 8'hAB, 0, 1);
        vt[11] = mk(GNT, 0,  8'h00, 0, 16'h0100, 0, 0, 16'h0100, 8'hAB, 0, 1);
        vt[12] = mk(DN,  0,  8'h77, 0, 16'hFFFF, 0, 0, 16'h0100, 8'h77, 0, 0);
        vt[13] = mk(WR, 31,  8'h20, 1, 16'hFFFF, 0, 0, 16'h0100, 8'h77, 0, 1);
        vt[14] = mk(GNT, 0,  8'h00, 0, 16'h0100, 1, 8'h20, 16'h0100, 8'h77, 0, 1);
        vt[15] = mk(DN,  0,  8'h00, 1, 16'hFFFF, 0, 0, 16'h0101, 8'h77, 0, 1);
        vt[16] = mk(GNT, 0,  8'h00, 0, 16'h0101, 0, 0, 16'h0101, 8'h77, 0, 1);
        vt[17] = mk(DN,  0,  8'h11, 0, 16'hFFFF, 0, 0, 16'h0101, 8'h11, 0, 0);
        vt[18] = mk(WR, 30,  8'h03, 1, 16'hFFFF, 0, 0, 16'h0101, 8'h11, 3, 1);
        vt[19] = mk(GNT, 0,  8'h00, 0, 16'h0101, 1, 8'h20, 16'h0101, 8'h11, 3, 1);
        vt[20] = mk(DN,  0,  8'h00, 1, 16'hFFFF, 0, 0, 16'h0102, 8'h11, 3, 1);
        vt[21] = mk(GNT, 0,  8'h00, 0, 16'h0102, 1, 8'h20, 16'h0102, 8'h11, 3, 1);
        vt[22] = mk(DN,  0,  8'h00, 1, 16'hFFFF, 0, 0, 16'h0103, 8'h11, 3, 1);
        vt[23] = mk(GNT, 0,  8'h00, 0, 16'h0103, 1, 8'h20, 16'h0103, 8'h11, 3, 1);
        vt[24] = mk(DN,  0,  8'h00, 0, 16'hFFFF, 0, 0, 16'h0104, 8'h11, 3, 0);

        reset = 1'b1; enableBus = 0; cs = 0; rs = 0; we = 0; regA = 0;
        db_in = 0; reg_copy = 0; slot_grant = 0; slot_done = 0;
        mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset wdata", mem_wdata, 8'h00);
        check("reset ba", reg_ba, 16'h0000);
        step(GNT, 6'd0, 8'h00);
        check("stray grant addr", mem_addr, 16'hFFFF);
        check("stray grant req", slot_req, 1'b0);

        for (int i = 0; i < 25; i++) begin
            step(vt[i].op, vt[i].ra, vt[i].d);
            check($sformatf("v%0d req", i), slot_req, vt[i].req);
            check($sformatf("v%0d addr", i), mem_addr, vt[i].addr);
            check($sformatf("v%0d we", i), mem_we, vt[i].mwe);
            if (vt[i].mwe) check($sformatf("v%0d wdata", i), mem_wdata, vt[i].wd);
            check($sformatf("v%0d ua", i), reg_ua, vt[i].ua);
            check($sformatf("v%0d da", i), reg_da, vt[i].da);
            check($sformatf("v%0d wc", i), reg_wc, vt[i].wc);
            check($sformatf("v%0d busy", i), busy, vt[i].bsy);
        end

        // block copy with BA wrapping through 0xFFFF
        reg_copy = 1'b1;
        step(WR, 6'd32, 8'hFF);
        step(WR, 6'd33, 8'hFF);
        step(WR, 6'd18, 8'h10);
        step(WR, 6'd19, 8'h00);
        step(WR, 6'd30, 8'h02);
        do_slot("copy rd0", 16'hFFFF, 1'b0, 8'h00, 8'hC1);
        do_slot("copy wr0", 16'h1000, 1'b1, 8'hC1, 8'h00);
        do_slot("copy rd1", 16'h0000, 1'b0, 8'h00, 8'hC2);
        do_slot("copy wr1", 16'h1001, 1'b1, 8'hC2, 8'h00);
        check("copy ba", reg_ba, 16'h0001);
        check("copy ua", reg_ua, 16'h1002);
        check("copy wc", reg_wc, 8'h02);
        check("copy busy", busy, 1'b0);

        // count 0 means 256 fill writes
        reg_copy = 1'b0;
        step(WR, 6'd30, 8'h00);
        n = 0;
        ea = 16'h1002;
        for (int k = 0; k < 300 && slot_req; k++) begin
            step(GNT, 6'd0, 8'h00);
            check("fill addr", mem_addr, ea);
            check("fill we", mem_we, 1'b1);
            step(DN, 6'd0, 8'h00);
            ea = ea + 16'd1;
            n++;
        end
        check("fill count", n, 256);
        check("fill ua", reg_ua, 16'h1102);
        check("fill busy", busy, 1'b0);

        // UA write during an in-flight fill abandons the fill
        step(WR, 6'd30, 8'h05);
        step(GNT, 6'd0, 8'h00);
        check("pend fill addr", mem_addr, 16'h1102);
        check("pend fill we", mem_we, 1'b1);
        step(WR, 6'd19, 8'h80);
        check("pend ua", reg_ua, 16'h1180);
        check("pend req", slot_req, 1'b0);
        check("pend busy", busy, 1'b1);
        step(DN, 6'd0, 8'h00);
        check("pend done ua", reg_ua, 16'h1180);
        do_slot("pend read", 16'h1180, 1'b0, 8'h00, 8'h5C);
        check("pend da", reg_da, 8'h5C);
        check("pend idle", busy, 1'b0);
        check("pend idle req", slot_req, 1'b0);

        // reset during an in-flight copy read
        reg_copy = 1'b1;
        step(WR, 6'd30, 8'h04);
        step(GNT, 6'd0, 8'h00);
        check("mid copy addr", mem_addr, 16'h0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst req", slot_req, 1'b0);
        check("rst addr", mem_addr, 16'hFFFF);
        check("rst we", mem_we, 1'b0);
        check("rst wdata", mem_wdata, 8'h00);
        check("rst ua", reg_ua, 16'h0000);
        check("rst ba", reg_ba, 16'h0000);
        check("rst wc", reg_wc, 8'h00);
        check("rst da", reg_da, 8'h00);
        check("rst busy", busy, 1'b0);
        step(DN, 6'd0, 8'h99);
        check("late done da", reg_da, 8'h00);
        check("late done busy", busy, 1'b0);
        check("late done req", slot_req, 1'b0);
        check("late done addr", mem_addr, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
